// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//   APB requester placed upstream of the add/subtract APB slave. It takes one
//   read or write command at a time from a local controller over a valid/ready
//   handshake. It runs the APB SETUP/ACCESS sequence and waits for PREADY, with
//   a bound of TIMEOUT ACCESS cycles. It then returns exactly one response
//   strobe for each command.
//
// Ports
//   PCLK, PRESET             clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (accepted only in IDLE)
//   cmd_write/addr/wdata     command fields, latched on acceptance
//   rsp_valid                one-cycle response strobe
//   rsp_rdata / rsp_err      response payload, held until the next response
//   busy                     high whenever the FSM is not in IDLE
//   PSEL/PENABLE/PWRITE      APB control, registered
//   PRWADDR/PRWDATA          APB address / write data, registered
//   PRDATA1/PREADY           APB read data / ready from the slave
// -----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PRWADDR,
  output logic [DATA_W-1:0] PRWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic              PREADY
);

  // The counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;

  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_busy;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              w_accept;
  logic              w_cmd_load;
  logic              w_rsp_load;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;

  // cmd_ready is registered and is high only in IDLE.
  assign w_accept = cmd_valid & r_cmd_ready;

  // Next-state, wait-counter and response-capture decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_cmd_load      = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cmd_load = 1'b1;
          if (cmd_addr[1:0] != 2'b00) begin
            // A misaligned address is rejected locally and never reaches the bus.
            w_state_nxt     = ST_RESP;
            w_rsp_load      = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = {DATA_W{1'b0}};
          end else begin
            w_state_nxt = ST_SETUP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt    = ST_ACCESS;
        w_wait_cnt_nxt = {CNT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (PREADY) begin
          // PREADY takes priority over a timeout in the same cycle.
          w_state_nxt     = ST_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? {DATA_W{1'b0}} : PRDATA1;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_state_nxt     = ST_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = {DATA_W{1'b0}};
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and all registered outputs. Control outputs are computed
  // from the next state, so they line up with the state they describe.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= {CNT_W{1'b0}};
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_W{1'b0}};
      r_pwdata    <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable   <= (w_state_nxt == ST_ACCESS);
      if (w_cmd_load) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end else begin
        r_pwrite <= r_pwrite;
        r_paddr  <= r_paddr;
        r_pwdata <= r_pwdata;
      end
      if (w_rsp_load) begin
        r_rsp_err   <= w_rsp_err_nxt;
        r_rsp_rdata <= w_rsp_rdata_nxt;
      end else begin
        r_rsp_err   <= r_rsp_err;
        r_rsp_rdata <= r_rsp_rdata;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PRWADDR   = r_paddr;
  assign PRWDATA   = r_pwdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//   Self-checking bench for apb_cmd_master. A reference model predicts each
//   response from the command and the chosen slave behaviour: alignment,
//   PREADY delay versus TIMEOUT, and read or write. The bench acts as the
//   slave, drives PREADY and PRDATA1, and checks bus timing and the response.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PRWADDR;
  logic [DATA_W-1:0] PRWDATA;
  logic [DATA_W-1:0] PRDATA1;
  logic              PREADY;

  int n_tests;
  int n_fail;

  // Fields presented while a held-valid command is still in flight.
  logic              nxt_write;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(PRDATA1), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Watchdog so that the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and act as a slave that gives PREADY after dly wait cycles.
  // The model expects: misaligned -> immediate error; dly >= TIMEOUT -> error
  // after TIMEOUT ACCESS cycles; otherwise success after dly+1 ACCESS cycles.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] sd, input int dly, input bit hold);
    bit          aligned, exp_err, got_rsp, stable_ok, proto_ok, ready_ok;
    int          exp_acc, exp_cyc, n_setup, n_acc, n_cyc, wcnt;
    logic [31:0] exp_rd;
    aligned = (addr[1:0] == 2'b00);
    exp_err = !aligned || (dly >= TIMEOUT);
    exp_acc = !aligned ? 0 : ((dly >= TIMEOUT) ? TIMEOUT : dly + 1);
    exp_cyc = aligned ? exp_acc + 2 : 1;
    exp_rd  = (exp_err || wr) ? 32'h0 : sd;

    wcnt = 0;
    while (!cmd_ready && wcnt < 50) begin
      @(negedge PCLK);
      wcnt++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge PCLK);
    if (hold) begin
      cmd_write = nxt_write;
      cmd_addr  = nxt_addr;
      cmd_wdata = nxt_wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom();
      cmd_wdata = $urandom();
    end

    n_setup = 0; n_acc = 0; n_cyc = 1; got_rsp = 1'b0;
    stable_ok = 1'b1; proto_ok = 1'b1; ready_ok = 1'b1;
    while (!got_rsp && n_cyc < 64) begin
      PREADY  = 1'b0;
      PRDATA1 = $urandom();
      if (rsp_valid) begin
        got_rsp = 1'b1;
      end else begin
        if (PSEL && !PENABLE) n_setup++;
        if (PENABLE && (!PSEL || n_setup == 0)) proto_ok = 1'b0;
        if (PSEL && (PRWADDR !== addr || PWRITE !== wr || PRWDATA !== wd)) stable_ok = 1'b0;
        if (cmd_ready || !busy) ready_ok = 1'b0;
        if (PSEL && PENABLE) begin
          PREADY = (n_acc == dly);
          if (PREADY) PRDATA1 = sd;
          n_acc++;
        end
        @(negedge PCLK);
        n_cyc++;
      end
    end
    PREADY = 1'b0;

    check("rsp_seen",     64'(got_rsp),   64'd1);
    check("rsp_err",      64'(rsp_err),   64'(exp_err));
    check("rsp_rdata",    64'(rsp_rdata), 64'(exp_rd));
    check("setup_cycles", 64'(n_setup),   64'(aligned ? 1 : 0));
    check("access_cycles",64'(n_acc),     64'(exp_acc));
    check("rsp_latency",  64'(n_cyc),     64'(exp_cyc));
    check("bus_stable",   64'(stable_ok), 64'd1);
    check("apb_protocol", 64'(proto_ok),  64'd1);
    check("ready_low_busy", 64'(ready_ok), 64'd1);
    check("psel_in_resp", 64'({PSEL, PENABLE}), 64'd0);

    @(negedge PCLK);
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("idle_after",    64'({busy, cmd_ready}), 64'b01);
    check("rsp_err_hold",  64'(rsp_err),   64'(exp_err));
    check("rsp_rdata_hold",64'(rsp_rdata), 64'(exp_rd));
  endtask

  initial begin
    int          pick, dly;
    logic [31:0] a;
    n_tests = 0; n_fail = 0;
    PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; PRDATA1 = 32'h0; PREADY = 1'b0;
    nxt_write = 1'b0; nxt_addr = 32'h0; nxt_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_ctrl", 64'({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, busy}), 64'd0);
    check("rst_data", 64'({PRWADDR, PRWDATA}), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Operand/flag writes then a read, slave ready on 2nd ACCESS cycle
    do_cmd(1'b1, 32'h0, 32'h5, 32'h0, 1, 1'b0);
    do_cmd(1'b1, 32'h4, 32'h3, 32'h0, 1, 1'b0);
    do_cmd(1'b1, 32'h8, 32'h1, 32'h0, 1, 1'b0);
    do_cmd(1'b0, 32'h0, 32'h0, 32'h8, 1, 1'b0);
    do_cmd(1'b1, 32'h0, 32'h3, 32'h0, 1, 1'b0);
    do_cmd(1'b1, 32'h4, 32'h5, 32'h0, 1, 1'b0);
    do_cmd(1'b1, 32'h8, 32'h0, 32'h0, 1, 1'b0);
    do_cmd(1'b0, 32'h0, 32'h0, 32'h80000002, 1, 1'b0);

    // Timeout, and PREADY exactly on the last allowed ACCESS cycle
    do_cmd(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1000, 1'b0);
    do_cmd(1'b0, 32'h0, 32'h0, 32'h12345678, TIMEOUT - 1, 1'b0);
    do_cmd(1'b1, 32'h4, 32'hCAFE, 32'h0, TIMEOUT, 1'b0);

    // Misaligned address
    do_cmd(1'b0, 32'h6, 32'h0, 32'h55, 0, 1'b0);

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_access", 64'({PSEL, PENABLE}), 64'b11);
    #2 PRESET = 1'b0;
    #1 check("rst_async_drop", 64'({PSEL, PENABLE, busy, rsp_valid, cmd_ready}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    check("ready_after_rst2", 64'(cmd_ready), 64'd1);
    do_cmd(1'b0, 32'h4, 32'h0, 32'h00000777, 1, 1'b0);

    // cmd_valid held high across two commands
    nxt_write = 1'b1; nxt_addr = 32'h8; nxt_wdata = 32'hA5A5A5A5;
    do_cmd(1'b0, 32'h0, 32'h0, 32'h00000042, 2, 1'b1);
    do_cmd(1'b1, 32'h8, 32'hA5A5A5A5, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("no_duplicate", 64'({PSEL, busy, rsp_valid}), 64'd0);
    end

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      a = {26'($urandom()), 4'($urandom_range(0, 2) * 4), 2'b00};
      if (pick == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (pick == 1) dly = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
      else           dly = $urandom_range(0, 3);
      do_cmd(1'($urandom_range(0, 1)), a, $urandom(), $urandom(), dly, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
